// File: rtl/axi_espulsore_pkg.sv
// Shared definitions for the multi-channel ejector: register offsets, channel
// FSM encoding, AXI response codes and address decode helpers.
package axi_espulsore_pkg;

    localparam logic [31:0] REG_CTRL   = 32'h00;
    localparam logic [31:0] REG_STATUS = 32'h04;
    localparam logic [31:0] REG_TRIG   = 32'h08;
    localparam logic [31:0] CH_BASE    = 32'h10;
    localparam logic [31:0] CH_STRIDE  = 32'h08;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, DELAY, PULSE} ch_state_t;

    typedef struct packed {
        logic       hit;
        logic       is_ctrl;
        logic       is_status;
        logic       is_trig;
        logic       is_ch;
        logic       fld_w;   // 0: DELAY_i, 1: WIDTH_i
        logic [3:0] ch;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] off, input int num_ch);
        dec_t d;
        d           = '0;
        d.is_ctrl   = (off == REG_CTRL);
        d.is_status = (off == REG_STATUS);
        d.is_trig   = (off == REG_TRIG);
        if (off >= CH_BASE && off < CH_BASE + CH_STRIDE * 32'(num_ch)) begin
            d.is_ch = 1'b1;
            d.ch    = 4'((off - CH_BASE) >> 3);
            d.fld_w = off[2];
        end
        d.hit = d.is_ctrl | d.is_status | d.is_trig | d.is_ch;
        return d;
    endfunction

    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        return r;
    endfunction

endpackage

// File: rtl/axi_espulsore_mc_ch.sv
// One ejector channel: trigger edge detect, IDLE/DELAY/PULSE sequencer with a
// shared down-counter, and an overrun pulse for triggers arriving while busy.
module espulsore_ch
    import axi_espulsore_pkg::*;
#(
    parameter int CNT_WIDTH = 24
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 trig_hw_i,
    input  logic                 trig_sw_i,
    input  logic [CNT_WIDTH-1:0] delay_i,
    input  logic [CNT_WIDTH-1:0] width_i,
    output logic                 eject_o,
    output logic                 busy_o,
    output logic                 ovr_set_o
);

    ch_state_t            state_q;
    logic [CNT_WIDTH-1:0] cnt_q, dly_q, wid_q;
    logic                 start_q, trig_q, eject_q;
    logic                 evt;

    assign evt       = trig_sw_i | (trig_hw_i & ~trig_q);
    // An accepted trigger is pending for one cycle before BUSY shows; a second
    // trigger in that window is an overrun as well.
    assign ovr_set_o = evt & (start_q | (state_q != IDLE));
    assign busy_o    = (state_q != IDLE);
    assign eject_o   = eject_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dly_q   <= '0;
            wid_q   <= '0;
            start_q <= 1'b0;
            trig_q  <= 1'b0;
            eject_q <= 1'b0;
        end else begin
            trig_q <= trig_hw_i;
            if (!en_i) begin
                state_q <= IDLE;
                start_q <= 1'b0;
                eject_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                start_q <= 1'b0;
                if (evt && state_q == IDLE && !start_q && width_i != '0) begin
                    start_q <= 1'b1;
                    dly_q   <= delay_i;
                    wid_q   <= width_i;
                end
                case (state_q)
                    IDLE: if (start_q) begin
                        if (dly_q == '0) begin
                            state_q <= PULSE;
                            eject_q <= 1'b1;
                            cnt_q   <= wid_q - CNT_WIDTH'(1);
                        end else begin
                            state_q <= DELAY;
                            cnt_q   <= dly_q - CNT_WIDTH'(1);
                        end
                    end
                    DELAY: if (cnt_q == '0) begin
                        state_q <= PULSE;
                        eject_q <= 1'b1;
                        cnt_q   <= wid_q - CNT_WIDTH'(1);
                    end else begin
                        cnt_q <= cnt_q - CNT_WIDTH'(1);
                    end
                    PULSE: if (cnt_q == '0) begin
                        state_q <= IDLE;
                        eject_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_WIDTH'(1);
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/axi_espulsore_mc.sv
// AXI4-Lite slave with CTRL/STATUS/TRIG and per-channel DELAY/WIDTH registers
// driving NUM_CH ejector channels.
module axi_espulsore_mc
    import axi_espulsore_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_CH             = 4,
    parameter int CNT_WIDTH          = 24
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    input  logic [NUM_CH-1:0]               trig_i,
    output logic [NUM_CH-1:0]               eject_o
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;

    logic                            en_q, en_d;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0] dly_q, dly_d, wid_q, wid_d;
    logic [NUM_CH-1:0]               ovr_q, ovr_d, ovr_clr, ovr_set, trig_sw, busy;
    logic                            wr_rdy_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]                      bresp_q, rresp_q, rresp_d;
    logic [31:0]                     rdata_q, rdata_d;
    logic                            wr_en, rd_en;
    dec_t                            wdec, rdec;
    logic                            unused_ok;

    assign wdec  = decode(32'({s_axi_awaddr[AW-1:2], 2'b00}), NUM_CH);
    assign rdec  = decode(32'({s_axi_araddr[AW-1:2], 2'b00}), NUM_CH);
    assign wr_en = wr_rdy_q & s_axi_awvalid & s_axi_wvalid;
    assign rd_en = arready_q & s_axi_arvalid;
    assign unused_ok = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], rdec.is_trig};

    always_comb begin
        en_d    = en_q;
        dly_d   = dly_q;
        wid_d   = wid_q;
        ovr_clr = '0;
        trig_sw = '0;
        if (wr_en && wdec.hit) begin
            if (wdec.is_ctrl && s_axi_wstrb[0]) en_d = s_axi_wdata[0];
            for (int i = 0; i < NUM_CH; i++) begin
                if (wdec.is_status) ovr_clr[i] = s_axi_wdata[16+i] & s_axi_wstrb[(16+i)/8];
                if (wdec.is_trig)   trig_sw[i] = s_axi_wdata[i] & s_axi_wstrb[i/8];
                if (wdec.is_ch && wdec.ch == 4'(i)) begin
                    if (wdec.fld_w)
                        wid_d[i] = CNT_WIDTH'(strb_merge(32'(wid_q[i]), s_axi_wdata, s_axi_wstrb));
                    else
                        dly_d[i] = CNT_WIDTH'(strb_merge(32'(dly_q[i]), s_axi_wdata, s_axi_wstrb));
                end
            end
        end
        // A new overrun in the same cycle as its W1C clear must survive.
        ovr_d = (ovr_q & ~ovr_clr) | ovr_set;
    end

    always_comb begin
        rdata_d = '0;
        rresp_d = rdec.hit ? RESP_OKAY : RESP_SLVERR;
        if (rdec.is_ctrl) rdata_d[0] = en_q;
        if (rdec.is_status) begin
            rdata_d[NUM_CH-1:0]   = busy;
            rdata_d[16 +: NUM_CH] = ovr_q;
        end
        for (int i = 0; i < NUM_CH; i++)
            if (rdec.is_ch && rdec.ch == 4'(i))
                rdata_d[CNT_WIDTH-1:0] = rdec.fld_w ? wid_q[i] : dly_q[i];
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            en_q      <= 1'b0;
            dly_q     <= '0;
            wid_q     <= '0;
            ovr_q     <= '0;
            wr_rdy_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            en_q  <= en_d;
            dly_q <= dly_d;
            wid_q <= wid_d;
            ovr_q <= ovr_d;
            // Ready may rise while the previous response is being taken,
            // which keeps back-to-back writes at one every two cycles.
            wr_rdy_q <= s_axi_awvalid & s_axi_wvalid & ~wr_rdy_q & (~bvalid_q | s_axi_bready);
            if (wr_en) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wdec.hit ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axi_bready) begin
                bvalid_q <= 1'b0;
            end
            arready_q <= s_axi_arvalid & ~arready_q & (~rvalid_q | s_axi_rready);
            if (rd_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdata_d;
                rresp_q  <= rresp_d;
            end else if (s_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign s_axi_awready = wr_rdy_q;
    assign s_axi_wready  = wr_rdy_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        espulsore_ch #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
            .clk_i     (ACLK),
            .rst_ni    (ARESETN),
            .en_i      (en_q),
            .trig_hw_i (trig_i[g]),
            .trig_sw_i (trig_sw[g]),
            .delay_i   (dly_q[g]),
            .width_i   (wid_q[g]),
            .eject_o   (eject_o[g]),
            .busy_o    (busy[g]),
            .ovr_set_o (ovr_set[g])
        );
    end

endmodule

// File: tb/tb_axi_espulsore_mc.sv
// Directed bench for axi_espulsore_mc: register access, pulse timing, overrun,
// byte strobes, EN clear and mid-pulse reset.
module tb_axi_espulsore_mc;

    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

    logic        ACLK = 1'b0, ARESETN = 1'b0;
    logic [5:0]  awaddr = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1;
    logic        arvalid = 1'b0, rready = 1'b1;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [3:0]  trig_i = '0;
    logic [3:0]  eject_o;

    int vecs = 0, errs = 0;
    logic [31:0] v;
    logic [1:0]  resp;

    always #5 ACLK = ~ACLK;

    axi_espulsore_mc dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .trig_i(trig_i), .eject_o(eject_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic axi_wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] r);
        logic ok = 1'b0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (awready && wready) begin ok = 1'b1; break; end
        end
        chk("wr_handshake", 32'(ok), 32'h1);
        if (ok) @(posedge ACLK);
        #1 awvalid = 1'b0; wvalid = 1'b0;
        @(negedge ACLK);
        r = bvalid ? bresp : 2'b11;
    endtask

    task automatic axi_rd(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
        logic ok = 1'b0;
        araddr = a; arvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (arready) begin ok = 1'b1; break; end
        end
        chk("rd_handshake", 32'(ok), 32'h1);
        if (ok) @(posedge ACLK);
        #1 arvalid = 1'b0;
        @(negedge ACLK);
        d = rvalid ? rdata : 32'hDEAD_BEEF;
        r = rvalid ? rresp : 2'b11;
    endtask

    task automatic wr_chk(input string tag, input logic [5:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] er);
        logic [1:0] r;
        axi_wr(a, d, s, r);
        chk({tag, "_bresp"}, 32'(r), 32'(er));
    endtask

    task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] ed,
                          input logic [1:0] er);
        logic [31:0] d;
        logic [1:0]  r;
        axi_rd(a, d, r);
        chk(tag, d, ed);
        chk({tag, "_rresp"}, 32'(r), 32'(er));
    endtask

    initial begin
        repeat (3) @(negedge ACLK);
        chk("rst_eject", 32'(eject_o), 32'h0);
        chk("rst_axi", 32'({awready, wready, bvalid, arready, rvalid, bresp, rresp}), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        ARESETN = 1'b1;
        @(negedge ACLK);

        for (int i = 0; i < 4; i++)
            wr_chk("wr_delay", 6'h10 + 6'(8 * i), 32'(i + 1), 4'hF, OKAY);
        for (int i = 0; i < 4; i++)
            rd_chk("rd_delay", 6'h10 + 6'(8 * i), 32'(i + 1), OKAY);
        rd_chk("rd_unmapped", 6'h3C, 32'h0, SLVERR);
        wr_chk("wr_unmapped", 6'h0C, 32'h1, 4'hF, SLVERR);
        rd_chk("rd_trig", 6'h08, 32'h0, OKAY);

        // width 0: trigger ignored
        wr_chk("wr_ctrl", 6'h00, 32'h1, 4'hF, OKAY);
        wr_chk("wr_dly0", 6'h10, 32'h3, 4'hF, OKAY);
        axi_wr(6'h08, 32'h1, 4'hF, resp);
        repeat (3) @(negedge ACLK);
        rd_chk("width0_ignored", 6'h04, 32'h0, OKAY);

        // DELAY=3 WIDTH=5: high after edges 4..8 counted from the handshake
        wr_chk("wr_wid0", 6'h14, 32'h5, 4'hF, OKAY);
        axi_wr(6'h08, 32'h1, 4'hF, resp);
        v = '0;
        v[0] = eject_o[0];
        for (int k = 1; k <= 12; k++) begin @(negedge ACLK); v[k] = eject_o[0]; end
        chk("ch0_pulse", v, 32'h1F0);

        axi_wr(6'h08, 32'h1, 4'hF, resp);
        rd_chk("busy_on", 6'h04, 32'h1, OKAY);
        repeat (12) @(negedge ACLK);
        rd_chk("busy_off", 6'h04, 32'h0, OKAY);

        // hardware trigger, DELAY=0 WIDTH=1
        wr_chk("wr_dly1", 6'h18, 32'h0, 4'hF, OKAY);
        wr_chk("wr_wid1", 6'h1C, 32'h1, 4'hF, OKAY);
        trig_i[1] = 1'b1;
        @(negedge ACLK);
        trig_i[1] = 1'b0;
        v = '0;
        v[0] = eject_o[1];
        for (int k = 1; k <= 3; k++) begin @(negedge ACLK); v[k] = eject_o[1]; end
        chk("ch1_hw_pulse", v, 32'h2);

        // retrigger channel 2 mid-pulse: pulse unchanged, OVR set
        wr_chk("wr_dly2", 6'h20, 32'h0, 4'hF, OKAY);
        wr_chk("wr_wid2", 6'h24, 32'd10, 4'hF, OKAY);
        axi_wr(6'h08, 32'h4, 4'hF, resp);
        axi_wr(6'h08, 32'h4, 4'hF, resp);
        v = '0;
        for (int k = 3; k <= 14; k++) begin @(negedge ACLK); v[k-3] = eject_o[2]; end
        chk("ch2_pulse_kept", v, 32'hFF);
        rd_chk("ovr_set", 6'h04, 32'h0004_0000, OKAY);
        wr_chk("ovr_clr_nostrb", 6'h04, 32'h0004_0000, 4'h3, OKAY);
        rd_chk("ovr_kept", 6'h04, 32'h0004_0000, OKAY);
        wr_chk("ovr_clr", 6'h04, 32'h0004_0000, 4'hF, OKAY);
        rd_chk("ovr_cleared", 6'h04, 32'h0, OKAY);

        wr_chk("wr_strb", 6'h10, 32'hAABB_CCDD, 4'b0010, OKAY);
        rd_chk("rd_strb", 6'h10, 32'h0000_CC03, OKAY);

        // EN clear mid-pulse, then trigger with EN=0 ignored
        wr_chk("wr_dly3", 6'h28, 32'h0, 4'hF, OKAY);
        wr_chk("wr_wid3", 6'h2C, 32'd1000, 4'hF, OKAY);
        axi_wr(6'h08, 32'h8, 4'hF, resp);
        repeat (3) @(negedge ACLK);
        chk("long_on", 32'(eject_o), 32'h8);
        axi_wr(6'h00, 32'h0, 4'hF, resp);
        @(negedge ACLK);
        chk("en_clr_drop", 32'(eject_o), 32'h0);
        rd_chk("en_clr_status", 6'h04, 32'h0, OKAY);
        axi_wr(6'h08, 32'h8, 4'hF, resp);
        repeat (3) @(negedge ACLK);
        chk("en0_ignored", 32'(eject_o), 32'h0);
        rd_chk("en0_status", 6'h04, 32'h0, OKAY);

        // reset mid-pulse
        axi_wr(6'h00, 32'h1, 4'hF, resp);
        axi_wr(6'h08, 32'h8, 4'hF, resp);
        repeat (3) @(negedge ACLK);
        chk("long_on2", 32'(eject_o), 32'h8);
        ARESETN = 1'b0;
        @(negedge ACLK);
        chk("rst_mid_eject", 32'(eject_o), 32'h0);
        chk("rst_mid_axi", 32'({awready, wready, bvalid, arready, rvalid, bresp, rresp}), 32'h0);
        ARESETN = 1'b1;
        @(negedge ACLK);
        rd_chk("rst_ctrl", 6'h00, 32'h0, OKAY);
        rd_chk("rst_dly0", 6'h10, 32'h0, OKAY);
        rd_chk("rst_wid3", 6'h2C, 32'h0, OKAY);
        rd_chk("rst_status", 6'h04, 32'h0, OKAY);
        chk("rst_no_eject", 32'(eject_o), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
